// File: rtl/bz_sound_pkg.sv
// Shared definitions for the sound control register: bit positions and shaper states.
package bz_sound_pkg;

  localparam int unsigned SND_EXPLO_LS  = 0;
  localparam int unsigned SND_SHELL_LS  = 1;
  localparam int unsigned SND_SHELL_REQ = 2;
  localparam int unsigned SND_EXPLO_REQ = 3;
  localparam int unsigned SND_RSVD      = 4;
  localparam int unsigned SND_SOUND_EN  = 5;
  localparam int unsigned SND_MOTOR_EN  = 6;
  localparam int unsigned SND_START_LED = 7;

  localparam logic [7:0] SND_REG_RESET = 8'h00;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HI_HOLD = 2'd1,
    HI      = 2'd2,
    LO_HOLD = 2'd3
  } trig_state_t;

endpackage

// File: rtl/bz_trig_shaper.sv
// Trigger shaper: stretches a CPU request into a pulse with minimum high and low times
// measured in clk_12KHz_en ticks, and freezes the loud/soft select for each trigger.
module bz_trig_shaper
  import bz_sound_pkg::*;
#(
  parameter int MIN_HIGH_TICKS = 2,
  parameter int MIN_LOW_TICKS  = 2,
  parameter int CNT_W          = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clk_12KHz_en,
  input  logic force_off,
  input  logic req,
  input  logic ls_in,
  output logic en,
  output logic ls_out
);

  localparam logic [CNT_W-1:0] HIGH_LOAD = CNT_W'(MIN_HIGH_TICKS);
  localparam logic [CNT_W-1:0] LOW_LOAD  = CNT_W'(MIN_LOW_TICKS);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  trig_state_t      state_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      en      <= 1'b0;
      ls_out  <= 1'b0;
    end else if (force_off) begin
      // Disabling sound overrides any hold in progress; ls_out keeps its last value.
      state_q <= IDLE;
      cnt_q   <= '0;
      en      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req) begin
            state_q <= HI_HOLD;
            cnt_q   <= HIGH_LOAD;
            en      <= 1'b1;
            ls_out  <= ls_in;
          end
        end
        HI_HOLD: begin
          if (clk_12KHz_en && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) state_q <= HI;
          end
        end
        HI: begin
          if (!req) begin
            state_q <= LO_HOLD;
            cnt_q   <= LOW_LOAD;
            en      <= 1'b0;
          end
        end
        LO_HOLD: begin
          if (clk_12KHz_en && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          en      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/bz_sound_ctrl.sv
// CPU-facing sound control register: latches the write port, drives the static enables
// directly and feeds the shell/explosion trigger shapers from the registered requests.
module bz_sound_ctrl
  import bz_sound_pkg::*;
#(
  parameter int MIN_HIGH_TICKS = 2,
  parameter int MIN_LOW_TICKS  = 2,
  parameter int CNT_W          = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_12KHz_en,
  input  logic       reg_wr,
  input  logic [7:0] reg_wdata,
  output logic [7:0] reg_rdata,
  output logic       sound_enable,
  output logic       shell_en,
  output logic       shell_ls,
  output logic       explo_en,
  output logic       explo_ls,
  output logic       motor_en,
  output logic       start_led
);

  logic [7:0] snd_reg;
  logic       force_off;

  always_ff @(posedge clk) begin
    if (rst)         snd_reg <= SND_REG_RESET;
    else if (reg_wr) snd_reg <= reg_wdata;
  end

  assign reg_rdata    = snd_reg;
  assign sound_enable = snd_reg[SND_SOUND_EN];
  assign motor_en     = snd_reg[SND_MOTOR_EN];
  assign start_led    = snd_reg[SND_START_LED];
  assign force_off    = ~snd_reg[SND_SOUND_EN];

  bz_trig_shaper #(
    .MIN_HIGH_TICKS (MIN_HIGH_TICKS),
    .MIN_LOW_TICKS  (MIN_LOW_TICKS),
    .CNT_W          (CNT_W)
  ) u_shell (
    .clk          (clk),
    .rst          (rst),
    .clk_12KHz_en (clk_12KHz_en),
    .force_off    (force_off),
    .req          (snd_reg[SND_SHELL_REQ]),
    .ls_in        (snd_reg[SND_SHELL_LS]),
    .en           (shell_en),
    .ls_out       (shell_ls)
  );

  bz_trig_shaper #(
    .MIN_HIGH_TICKS (MIN_HIGH_TICKS),
    .MIN_LOW_TICKS  (MIN_LOW_TICKS),
    .CNT_W          (CNT_W)
  ) u_explo (
    .clk          (clk),
    .rst          (rst),
    .clk_12KHz_en (clk_12KHz_en),
    .force_off    (force_off),
    .req          (snd_reg[SND_EXPLO_REQ]),
    .ls_in        (snd_reg[SND_EXPLO_LS]),
    .en           (explo_en),
    .ls_out       (explo_ls)
  );

endmodule

// File: tb/tb_bz_sound_ctrl.sv
// Self-checking bench for bz_sound_ctrl: a cycle model pushes expected outputs into a
// scoreboard queue as stimulus is driven; they are popped and compared after each edge.
module tb_bz_sound_ctrl;

  localparam int MH = 2;
  localparam int ML = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clk_12KHz_en = 1'b0;
  logic       reg_wr = 1'b0;
  logic [7:0] reg_wdata = 8'h00;
  logic [7:0] reg_rdata;
  logic       sound_enable, shell_en, shell_ls, explo_en, explo_ls, motor_en, start_led;

  bz_sound_ctrl #(.MIN_HIGH_TICKS(MH), .MIN_LOW_TICKS(ML), .CNT_W(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .clk_12KHz_en (clk_12KHz_en),
    .reg_wr       (reg_wr),
    .reg_wdata    (reg_wdata),
    .reg_rdata    (reg_rdata),
    .sound_enable (sound_enable),
    .shell_en     (shell_en),
    .shell_ls     (shell_ls),
    .explo_en     (explo_en),
    .explo_ls     (explo_ls),
    .motor_en     (motor_en),
    .start_led    (start_led)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] rdata;
    logic       se, sh_en, sh_ls, ex_en, ex_ls, motor, led;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   tick_ph  = 0;

  // Reference model: phase 0 idle, 1 high-hold, 2 high, 3 low-hold.
  logic [7:0] m_reg = 8'h00;
  int         m_ph[2];
  int         m_left[2];
  bit         m_en[2];
  bit         m_ls[2];

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] want);
    n_checks++;
    if (obs !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, want, $time);
    end
  endtask

  task automatic model(input bit r, input bit wr, input logic [7:0] d, input bit tk);
    logic [7:0] prev;
    bit req, lsb;
    prev = m_reg;
    if (r) begin
      m_reg = 8'h00;
      for (int c = 0; c < 2; c++) begin
        m_ph[c] = 0; m_left[c] = 0; m_en[c] = 0; m_ls[c] = 0;
      end
      return;
    end
    for (int c = 0; c < 2; c++) begin
      req = (c == 0) ? prev[2] : prev[3];
      lsb = (c == 0) ? prev[1] : prev[0];
      if (!prev[5]) begin
        m_ph[c] = 0; m_left[c] = 0; m_en[c] = 0;
      end else if (m_ph[c] == 0) begin
        if (req) begin m_ph[c] = 1; m_left[c] = MH; m_en[c] = 1; m_ls[c] = lsb; end
      end else if (m_ph[c] == 2) begin
        if (!req) begin m_ph[c] = 3; m_left[c] = ML; m_en[c] = 0; end
      end else if (tk && m_left[c] > 0) begin
        m_left[c] = m_left[c] - 1;
        if (m_left[c] == 0) m_ph[c] = (m_ph[c] == 1) ? 2 : 0;
      end
    end
    if (wr) m_reg = d;
  endtask

  task automatic step(input bit r, input bit wr, input logic [7:0] d, input bit tk);
    exp_t e;
    @(negedge clk);
    rst = r; reg_wr = wr; reg_wdata = d; clk_12KHz_en = tk;
    model(r, wr, d, tk);
    e.rdata = m_reg; e.se = m_reg[5]; e.motor = m_reg[6]; e.led = m_reg[7];
    e.sh_en = m_en[0]; e.sh_ls = m_ls[0]; e.ex_en = m_en[1]; e.ex_ls = m_ls[1];
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("reg_rdata",    reg_rdata,           e.rdata);
    chk("sound_enable", {7'b0, sound_enable}, {7'b0, e.se});
    chk("shell_en",     {7'b0, shell_en},     {7'b0, e.sh_en});
    chk("shell_ls",     {7'b0, shell_ls},     {7'b0, e.sh_ls});
    chk("explo_en",     {7'b0, explo_en},     {7'b0, e.ex_en});
    chk("explo_ls",     {7'b0, explo_ls},     {7'b0, e.ex_ls});
    chk("motor_en",     {7'b0, motor_en},     {7'b0, e.motor});
    chk("start_led",    {7'b0, start_led},    {7'b0, e.led});
  endtask

  // Free-running ticks every 4 clks.
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      step(0, 0, 8'h00, (tick_ph % 4) == 3);
      tick_ph++;
    end
  endtask

  task automatic wr_tick(input logic [7:0] d);
    step(0, 1, d, (tick_ph % 4) == 3);
    tick_ph++;
  endtask

  int hi_cycles;

  initial begin
    for (int c = 0; c < 2; c++) begin
      m_ph[c] = 0; m_left[c] = 0; m_en[c] = 0; m_ls[c] = 0;
    end

    // Reset state
    step(1, 0, 8'h00, 0);
    step(1, 0, 8'h00, 1);
    chk("reset_rdata", reg_rdata, 8'h00);
    chk("reset_outs", {1'b0, sound_enable, shell_en, shell_ls, explo_en, explo_ls, motor_en, start_led}, 8'h00);

    // Write 2C: both triggers rise one clk after the write edge
    step(0, 1, 8'h2C, 0);
    chk("s1_rdata", reg_rdata, 8'h2C);
    chk("s1_en_not_yet", {6'b0, shell_en, explo_en}, 8'h00);
    step(0, 0, 8'h00, 0);
    chk("s1_en_rise", {6'b0, shell_en, explo_en}, 8'h03);
    run(12);
    wr_tick(8'h20);
    run(16);

    // Short request: 24 then 20 next clk; pulse must still last MIN_HIGH ticks
    wr_tick(8'h24);
    wr_tick(8'h20);
    hi_cycles = 1;
    for (int i = 0; i < 20; i++) begin
      run(1);
      if (shell_en) hi_cycles++;
    end
    chk("s2_hi_len_min", {7'b0, (hi_cycles >= 5)}, 8'h01);
    run(8);

    // ls frozen per trigger
    wr_tick(8'h24);
    run(10);
    wr_tick(8'h22);
    run(2);
    chk("s3_ls_held", {7'b0, shell_ls}, 8'h00);
    run(14);
    wr_tick(8'h26);
    run(1);
    chk("s3_ls_second", {6'b0, shell_en, shell_ls}, 8'h03);
    run(6);

    // Sound disable mid-HI_HOLD
    wr_tick(8'h00);
    run(10);
    step(0, 1, 8'h28, 0);
    step(0, 0, 8'h00, 0);
    chk("s4_explo_on", {7'b0, explo_en}, 8'h01);
    step(0, 1, 8'h08, 0);
    step(0, 0, 8'h00, 1);
    chk("s4_force_off", {6'b0, explo_en, sound_enable}, 8'h00);
    run(4);

    // Reset during HI_HOLD
    step(0, 1, 8'hEC, 0);
    step(0, 0, 8'h00, 0);
    chk("s5_hold", {6'b0, shell_en, explo_en}, 8'h03);
    step(1, 0, 8'h00, 0);
    chk("s5_rst_rdata", reg_rdata, 8'h00);
    chk("s5_rst_outs", {1'b0, sound_enable, shell_en, shell_ls, explo_en, explo_ls, motor_en, start_led}, 8'h00);

    // Same-clk write and tick in LO_HOLD with one tick left
    step(0, 1, 8'h24, 0);
    step(0, 0, 8'h00, 0);
    step(0, 0, 8'h00, 1);
    step(0, 0, 8'h00, 1);
    step(0, 1, 8'h20, 0);
    step(0, 0, 8'h00, 0);
    chk("s6_lo_hold", {7'b0, shell_en}, 8'h00);
    step(0, 0, 8'h00, 1);
    step(0, 1, 8'h24, 1);
    chk("s6_idle_low", {7'b0, shell_en}, 8'h00);
    step(0, 0, 8'h00, 0);
    chk("s6_retrigger", {7'b0, shell_en}, 8'h01);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic [7:0] d;
      d = 8'($urandom);
      if ($urandom_range(0, 3) != 0) d[5] = 1'b1;
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 4) == 0), d, ($urandom_range(0, 2) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
